eth_rx_filter: RTL

ETH_RX_FILTER -- requirements
Module: eth_rx_filter

---
 rtl/eth_rx_filter_if.sv | 24 ++
 rtl/eth_rx_filter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eth_rx_filter_if.sv
// Dibit stream in/out of the RX filter plus its end-of-frame status and statistics.
interface eth_rx_filter_if;
  logic        rx_axi_valid;
  logic [1:0]  rx_axi_data;
  logic        out_axi_valid;
  logic [1:0]  out_axi_data;
  logic        frame_done;
  logic        frame_good;
  logic [3:0]  err_flags;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  modport master (
    output rx_axi_valid, rx_axi_data,
    input  out_axi_valid, out_axi_data, frame_done, frame_good, err_flags,
           good_count, bad_count
  );

  modport slave (
    input  rx_axi_valid, rx_axi_data,
    output out_axi_valid, out_axi_data, frame_done, frame_good, err_flags,
           good_count, bad_count
  );
endinterface

// File: rtl/eth_rx_filter.sv
// RMII dibit RX filter (dest MAC, FCS, length); 1-cycle pass-through, status strobe 1 cycle after frame end.
// No backpressure; optional good/bad frame counters enabled by RX_FILTER_STATS_EN.
module eth_rx_filter #(
  parameter logic [47:0] MY_MAC = 48'h02_00_00_00_00_01
) (
  input  logic           clk,
  input  logic           rstn,
  eth_rx_filter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HDR, BODY, DISCARD} state_t;

  typedef struct packed {
    logic addr_miss;
    logic fcs_bad;
    logic runt;
    logic giant;
  } err_t;

  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_SEED     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
  localparam logic [12:0] HDR_LAST     = 13'd23;
  localparam logic [12:0] RUNT_DIBITS  = 13'd256;
  localparam logic [12:0] GIANT_DIBITS = 13'd6072;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        mac_hit_q, mac_hit_d;
  logic        bc_hit_q, bc_hit_d;
  logic        out_vld_q, out_vld_d;
  logic [1:0]  out_dat_q, out_dat_d;
  logic        done_q, done_d;
  logic        good_q, good_d;
  err_t        err_q, err_d;

  logic [12:0] idx;
  logic [31:0] crc_base;
  logic        frame_end;
  err_t        end_flags;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Byte 0 of the address is MY_MAC[47:40]; each byte goes out LSB dibit first.
  function automatic logic [1:0] mac_dibit(input logic [4:0] i);
    logic [5:0]  lo;
    logic [47:0] sh;
    lo = 6'd40 - {i[4:2], 3'b000} + {3'b000, i[1:0], 1'b0};
    sh = MY_MAC >> lo;
    return sh[1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    mac_hit_d = mac_hit_q;
    bc_hit_d  = bc_hit_q;
    done_d    = 1'b0;
    good_d    = good_q;
    err_d     = err_q;
    frame_end = 1'b0;
    end_flags = '0;

    idx      = (state_q == IDLE) ? 13'd0 : cnt_q;
    crc_base = (state_q == IDLE) ? CRC_SEED : crc_q;

    if (bus.rx_axi_valid) begin
      crc_d = crc_dibit(crc_base, bus.rx_axi_data);
      cnt_d = (idx == '1) ? idx : idx + 13'd1;
      if (idx <= HDR_LAST) begin
        mac_hit_d = ((state_q == IDLE) | mac_hit_q) & (bus.rx_axi_data == mac_dibit(idx[4:0]));
        bc_hit_d  = ((state_q == IDLE) | bc_hit_q) & (bus.rx_axi_data == 2'b11);
      end
    end

    case (state_q)
      IDLE:    if (bus.rx_axi_valid) state_d = HDR;
      HDR:     if (!bus.rx_axi_valid) frame_end = 1'b1;
               else if (cnt_q == HDR_LAST) state_d = BODY;
      BODY:    if (!bus.rx_axi_valid) frame_end = 1'b1;
               else if (cnt_q == GIANT_DIBITS) state_d = DISCARD;
      DISCARD: if (!bus.rx_axi_valid) frame_end = 1'b1;
      default: state_d = IDLE;
    endcase

    // A frame cut short in the header cannot have a full address or FCS.
    if (frame_end) begin
      end_flags.addr_miss = (state_q == HDR) | ~(mac_hit_q | bc_hit_q);
      end_flags.fcs_bad   = (state_q == HDR) | (crc_q != CRC_RESIDUE) | (cnt_q[1:0] != 2'b00);
      end_flags.runt      = (cnt_q < RUNT_DIBITS);
      end_flags.giant     = (state_q == DISCARD);
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b1;
      err_d   = end_flags;
      good_d  = ~|end_flags;
    end

    out_vld_d = bus.rx_axi_valid & (state_d != DISCARD);
    out_dat_d = bus.rx_axi_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      mac_hit_q <= 1'b0;
      bc_hit_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      done_q    <= 1'b0;
      good_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      mac_hit_q <= mac_hit_d;
      bc_hit_q  <= bc_hit_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      done_q    <= done_d;
      good_q    <= good_d;
      err_q     <= err_d;
    end
  end

  assign bus.out_axi_valid = out_vld_q;
  assign bus.out_axi_data  = out_dat_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_good    = good_q;
  assign bus.err_flags     = err_q;

`ifdef RX_FILTER_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  // Counters move on the same edge that raises frame_done.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (done_d) begin
      if (good_d) begin
        if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
      end else begin
        if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign bus.good_count = good_cnt_q;
  assign bus.bad_count  = bad_cnt_q;
`else
  assign bus.good_count = 16'h0000;
  assign bus.bad_count  = 16'h0000;
`endif
endmodule
